// File: rtl/aes_core_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_core_arbiter_if
// Purpose  : Requester request/response channels plus the AES core port.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_core_arbiter_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_key;
    logic [255:0] req_text;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [127:0] resp_data;
    logic         resp_err;
    logic         core_ld;
    logic [127:0] core_key;
    logic [127:0] core_text;
    logic         core_done;
    logic [127:0] core_text_out;
    logic         core_rst_n;

    modport slave (
        input  req_valid, req_key, req_text, resp_ready, core_done, core_text_out,
        output req_ready, resp_valid, resp_data, resp_err, core_ld, core_key,
               core_text, core_rst_n
    );

    modport master (
        output req_valid, req_key, req_text, resp_ready, core_done, core_text_out,
        input  req_ready, resp_valid, resp_data, resp_err, core_ld, core_key,
               core_text, core_rst_n
    );
endinterface
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_core_arbiter
// Purpose  : Round-robin sharing of one AES-128 core between two requesters.
//            Optional core watchdog: define AES_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_core_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    aes_core_arbiter_if.slave     bus,
    output logic [CNT_W-1:0]      job_cnt0,
    output logic [CNT_W-1:0]      job_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BUSY = 2'd2,
        S_RESP = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("aes_core_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t             state_q;
    logic               last_grant_q;
    logic               owner_q;
    logic               core_ld_q;
    logic [127:0]       core_key_q;
    logic [127:0]       core_text_q;
    logic [1:0]         resp_valid_q;
    logic [127:0]       resp_data_q;
    logic [CNT_W-1:0]   job_cnt0_q;
    logic [CNT_W-1:0]   job_cnt1_q;
    logic               w_grant;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMR_W-1:0] timer_q;
    logic               resp_err_q;
    logic               core_rst_n_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.core_rst_n = core_rst_n_q;
`else
    assign bus.resp_err   = 1'b0;
    assign bus.core_rst_n = 1'b1;
`endif

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_grant = 1'b0;
        case (bus.req_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~last_grant_q;
            default: w_grant = 1'b0;
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE) ? (bus.req_valid & (2'b01 << w_grant)) : 2'b00;
    assign bus.core_ld    = core_ld_q;
    assign bus.core_key   = core_key_q;
    assign bus.core_text  = core_text_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign job_cnt0       = job_cnt0_q;
    assign job_cnt1       = job_cnt1_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            core_ld_q    <= 1'b0;
            core_key_q   <= '0;
            core_text_q  <= '0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            job_cnt0_q   <= '0;
            job_cnt1_q   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            timer_q      <= '0;
            resp_err_q   <= 1'b0;
            core_rst_n_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|bus.req_ready) begin
                        core_key_q   <= w_grant ? bus.req_key[255:128]  : bus.req_key[127:0];
                        core_text_q  <= w_grant ? bus.req_text[255:128] : bus.req_text[127:0];
                        owner_q      <= w_grant;
                        last_grant_q <= w_grant;
                        core_ld_q    <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    core_ld_q <= 1'b0;
                    state_q   <= S_BUSY;
`ifdef AES_ARB_TIMEOUT_EN
                    timer_q   <= '0;
`endif
                end
                S_BUSY: begin
                    if (bus.core_done) begin
                        resp_data_q  <= bus.core_text_out;
                        resp_valid_q <= 2'b01 << owner_q;
                        state_q      <= S_RESP;
`ifdef AES_ARB_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
                    end else if (timer_q == c_TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        // Core is hung: reset it for one cycle and abort the job.
                        core_rst_n_q <= 1'b0;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                        resp_valid_q <= 2'b01 << owner_q;
                        state_q      <= S_RESP;
                    end else begin
                        timer_q <= timer_q + c_TMR_W'(1);
`endif
                    end
                end
                S_RESP: begin
`ifdef AES_ARB_TIMEOUT_EN
                    core_rst_n_q <= 1'b1;
`endif
                    if (bus.resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        if (owner_q) job_cnt1_q <= job_cnt1_q + CNT_W'(1);
                        else         job_cnt0_q <= job_cnt0_q + CNT_W'(1);
`ifdef AES_ARB_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
`endif
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_core_arbiter
// Purpose  : Scoreboard bench for aes_core_arbiter with a stub xor core.
//            Timeout scenario follows AES_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_core_arbiter;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    typedef struct packed {
        logic         owner;
        logic         err;
        logic [127:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] job_cnt0, job_cnt1;
    aes_core_arbiter_if bus();

    aes_core_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .job_cnt0 (job_cnt0),
        .job_cnt1 (job_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stub core: done one cycle, five cycles after ld, with text ^ key.
    logic         stub_en   = 1'b1;
    logic         stub_done = 1'b0;
    logic [127:0] stub_out  = '0;
    logic [127:0] stub_res  = '0;
    int           stub_cnt  = 0;
    int           ld_total  = 0;
    int           rstn_low  = 0;
    assign bus.core_done     = stub_done;
    assign bus.core_text_out = stub_out;

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (bus.core_ld === 1'b1) begin
            ld_total <= ld_total + 1;
            stub_cnt <= 5;
            stub_res <= bus.core_text ^ bus.core_key;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && stub_en) begin
                stub_done <= 1'b1;
                stub_out  <= stub_res;
            end
        end
    end

    always @(negedge clk) if (bus.core_rst_n === 1'b0) rstn_low++;

    // Reference model state
    exp_t         sb[$];
    logic         m_last = 1'b1;
    logic [15:0]  m_cnt0 = '0, m_cnt1 = '0;
    int           jobs_started = 0;
    int           bp_left = 0;
    logic [127:0] cur_k[2], cur_t[2];

    // Monitor: drives resp_ready and checks each response on its handshake.
    logic         cnt_pend = 1'b0;
    logic         prev_valid = 1'b0;
    logic [1:0]   prev_rv, mon_nr;
    logic [127:0] prev_data;
    logic         mon_own;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (cnt_pend) begin
            chk("job_cnt0", job_cnt0, m_cnt0);
            chk("job_cnt1", job_cnt1, m_cnt1);
            cnt_pend = 1'b0;
        end
        mon_nr = 2'($urandom);
        if (reset === 1'b1 && bus.resp_valid != 2'b00) begin
            mon_own = bus.resp_valid[1];
            chk("req_ready_in_resp", bus.req_ready, 2'b00);
            chk("ld_in_resp", bus.core_ld, 1'b0);
            if (prev_valid)
                chk("resp_stable", {bus.resp_valid, bus.resp_data}, {prev_rv, prev_data});
            if (bp_left > 0 && mon_own) begin
                mon_nr[1] = 1'b0;
                bp_left--;
            end
            if (mon_nr[mon_own]) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got resp_valid %b expected none", bus.resp_valid);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_owner", bus.resp_valid, 2'b01 << mon_e.owner);
                    chk("resp_data", bus.resp_data, mon_e.data);
                    chk("resp_err", bus.resp_err, mon_e.err);
                    chk("ld_pulses", ld_total, jobs_started);
                    if (mon_e.owner) m_cnt1++; else m_cnt0++;
                    cnt_pend = 1'b1;
                end
                prev_valid = 1'b0;
            end else begin
                prev_valid = 1'b1;
                prev_rv    = bus.resp_valid;
                prev_data  = bus.resp_data;
            end
        end else begin
            prev_valid = 1'b0;
        end
        bus.resp_ready = mon_nr;
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [127:0] k0, t0, k1, t1);
        cur_k[0] = k0; cur_t[0] = t0; cur_k[1] = k1; cur_t[1] = t1;
        bus.req_valid = v;
        bus.req_key   = {k1, k0};
        bus.req_text  = {t1, t0};
    endtask

    // Waits for the grant, predicts the response, then releases or holds the request.
    task automatic accept(input logic hold, input logic push, input logic err_exp);
        logic g;
        int   n;
        g = (bus.req_valid == 2'b01) ? 1'b0 : (bus.req_valid == 2'b10) ? 1'b1 : ~m_last;
        #1;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("grant", bus.req_ready, 2'b01 << g);
        if (bus.req_ready == 2'b00) return;
        if (push) sb.push_back('{owner: g, err: err_exp,
                                 data: err_exp ? 128'd0 : (cur_k[g] ^ cur_t[g])});
        m_last = g;
        jobs_started++;
        @(negedge clk);
        if (!hold) begin
            bus.req_valid = 2'b00;
            bus.req_key   = {rnd128(), rnd128()};
            bus.req_text  = {rnd128(), rnd128()};
        end
    endtask

    task automatic wait_empty(input int settle);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk); n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (settle) @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_resp_data", bus.resp_data, 128'd0);
        chk("rst_core_ld", bus.core_ld, 1'b0);
        chk("rst_core_key", bus.core_key, 128'd0);
        chk("rst_core_text", bus.core_text, 128'd0);
        chk("rst_core_rst_n", bus.core_rst_n, 1'b1);
        chk("rst_cnt", {job_cnt1, job_cnt0}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 2'b00;
        sb.delete();
        @(negedge clk);
        check_reset_values();
        reset  = 1'b1;
        m_last = 1'b1;
        m_cnt0 = '0;
        m_cnt1 = '0;
    endtask

    initial begin
        logic [1:0] v;
        logic       bad;
        int         base;
        reset = 1'b0;
        drive(2'b00, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b1;
        @(negedge clk);

        // Known-answer single job on requester 0
        drive(2'b01, 128'hcafebabedeadbeefdeadbeef00000000,
              128'h1237e5aa81d55aca4c1ac60b635264d3, rnd128(), rnd128());
        accept(1'b0, 1'b1, 1'b0);
        wait_empty(2);
        chk("kat_cnt0", job_cnt0, 16'd1);

        // Contention: both held valid, grants must alternate from requester 0
        do_reset();
        drive(2'b11, rnd128(), rnd128(), rnd128(), rnd128());
        for (int i = 0; i < 4; i++) begin
            accept(1'b1, 1'b1, 1'b0);
            if (i < 3) drive(2'b11, rnd128(), rnd128(), rnd128(), rnd128());
            else       bus.req_valid = 2'b00;
            wait_empty(0);
        end
        repeat (2) @(negedge clk);
        chk("contention_cnt", {job_cnt1, job_cnt0}, {16'd2, 16'd2});

        // Backpressure on requester 1
        bp_left = 10;
        drive(2'b10, rnd128(), rnd128(), rnd128(), rnd128());
        accept(1'b0, 1'b1, 1'b0);
        wait_empty(2);
        chk("bp_consumed", bp_left, 0);

        // Randomized mix
        for (int i = 0; i < 12; i++) begin
            v = 2'($urandom_range(1, 3));
            drive(v, rnd128(), rnd128(), rnd128(), rnd128());
            accept(1'b0, 1'b1, 1'b0);
            wait_empty(2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in BUSY; the stub's late done must be ignored
        drive(2'b01, rnd128(), rnd128(), rnd128(), rnd128());
        accept(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00) bad = 1'b1;
        end
        chk("late_done_ignored", bad, 1'b0);
        drive(2'b10, rnd128(), rnd128(), rnd128(), rnd128());
        accept(1'b0, 1'b1, 1'b0);
        wait_empty(2);
        chk("post_reset_cnt1", job_cnt1, 16'd1);

        // Hung core
        stub_en = 1'b0;
        base = rstn_low;
        drive(2'b01, rnd128(), rnd128(), rnd128(), rnd128());
`ifdef AES_ARB_TIMEOUT_EN
        accept(1'b0, 1'b1, 1'b1);
        wait_empty(2);
        chk("core_rst_pulse", rstn_low - base, 1);
`else
        accept(1'b0, 1'b0, 1'b0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00 || bus.resp_err !== 1'b0 || bus.core_rst_n !== 1'b1)
                bad = 1'b1;
        end
        chk("no_timeout_wait", bad, 1'b0);
        chk("core_rst_n_const", rstn_low - base, 0);
        do_reset();
`endif
        stub_en = 1'b1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

endmodule
`default_nettype wire

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Shares one AES-128 encryption core (`ld`/`done`/`key`/`text_in`/`text_out` interface) between two independent requesters.
- Accepts one job at a time from either requester using round-robin arbitration.
- Registers and holds the key and plaintext into the core, and pulses the core's `ld` for exactly one cycle.
- Waits for `done`, then returns the ciphertext to the owning requester over a valid/ready response channel.
- Sits between requester logic (key/IV engines, DMA) and the single core instance.

Parameters:
TIMEOUT_CYCLES, 64, watchdog limit in clock cycles while waiting for core_done (used only with the optional feature).
CNT_W, 16, width of the per-requester completed-job counters.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
req_valid  input  2  per-requester job request; bit i = requester i
req_ready  output  2  per-requester job accept
req_key  input  2x128 (flattened 256)  key; bits [128*i+127:128*i] belong to requester i
req_text  input  2x128 (flattened 256)  plaintext, same packing as req_key
resp_valid  output  2  ciphertext available for requester i
resp_ready  input  2  requester i takes the response
resp_data  output  128  ciphertext, shared by both requesters, qualified by resp_valid
resp_err  output  1  response is an abort, not ciphertext (tied 0 without the optional feature)
core_ld  output  1  one-cycle load strobe to the core
core_key  output  128  key to the core, held stable from LOAD until the job ends
core_text  output  128  plaintext to the core, held stable from LOAD until the job ends
core_done  input  1  core completion strobe
core_text_out  input  128  core ciphertext, sampled when core_done=1
core_rst_n  output  1  core reset (constant 1 without the optional feature)
job_cnt0, job_cnt1  output  CNT_W each  completed-response counters, one per requester

Behaviour:
- Reset: reset=0 at a rising edge forces the following.
  - state=IDLE, core_ld=0, req_ready=0, resp_valid=0, resp_err=0.
  - resp_data=0, core_key=0, core_text=0, core_rst_n=1.
  - job_cnt0=job_cnt1=0, last_grant=1, so requester 0 wins the first tie.
  - Reset mid-job drops the job with no response. The next job after reset re-issues core_ld normally.
- FSM states: IDLE, LOAD, BUSY, RESP.
- IDLE
  - Grant rule: if exactly one req_valid bit is set, grant that requester. If both are set, grant the requester != last_grant.
  - req_ready[g] is 1 combinationally in IDLE for the granted requester only; both bits are 0 in every other state.
  - On handshake at cycle T: capture req_key/req_text of g into core_key/core_text, set owner=g, set last_grant=g, go to LOAD.
- LOAD
  - core_ld=1 for exactly this one cycle (T+1), then go to BUSY.
- BUSY
  - core_ld=0.
  - On core_done=1: register core_text_out into resp_data, resp_err=0, go to RESP. resp_valid[owner]=1 from the next cycle.
  - core_done outside BUSY is ignored.
- RESP
  - resp_valid[owner] is held with resp_data stable until resp_ready[owner]=1.
  - resp_ready of the non-owner is ignored.
  - On handshake: clear resp_valid, increment job_cnt[owner] (wraps at 2^CNT_W), go to IDLE.
  - A new request can be accepted in the cycle after the response handshake, not in the same cycle.
- Only one job is ever outstanding.
- Request inputs may change freely when not handshaking. Captured values are unaffected by later changes.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in BUSY. If core_done has not arrived after TIMEOUT_CYCLES cycles in BUSY, the arbiter drives core_rst_n=0 for exactly one cycle.
  - It then goes to RESP with resp_err=1 and resp_data=0. The owner receives the error response normally.
  - The counter clears on entry to BUSY.
- When not defined: no counter logic; resp_err=0 and core_rst_n=1 constantly, and BUSY waits indefinitely.

Test Plan:
- The bench uses a stub core: done 5 cycles after ld, text_out = text_in ^ key.
- Single job: req0 key=cafebabedeadbeefdeadbeef00000000, text=1237e5aa81d55aca4c1ac60b635264d3 -> exactly one core_ld pulse; resp_valid[0] with resp_data=d8c95f145f78e42592b778e4635264d3; job_cnt0=1.
- Contention: req0 and req1 both held valid for 4 jobs -> grant order 0,1,0,1; job_cnt0=job_cnt1=2; resp_valid never asserted to the wrong requester.
- Backpressure: resp_ready[1]=0 for 10 cycles after resp_valid[1] -> resp_data stable; req_ready stays 00; no core_ld; response completes when resp_ready[1] rises.
- Reset mid-job: assert reset=0 during BUSY -> all outputs return to reset values next cycle; a later core_done is ignored; a fresh req1 job completes normally.
- Timeout (AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, stub never asserts done) -> one-cycle core_rst_n=0 pulse; resp_err=1 with resp_data=0 to the owner. Without the macro, the bench checks resp_err stays 0.
